// File: rtl/icon_rom_arbiter.sv
// -----------------------------------------------------------------------------
// icon_rom_arbiter
//
// Shares one 2048 x 2-bit icon ROM between four requesters.
//   - Port 0 is the VGA icon renderer. Its pixel timing is hard, so it wins
//     any cycle in which no background port is starved.
//   - Ports 1-3 are background users (minimap, preloader, debug readback).
//     They share leftover slots round-robin.
//   - A per-port starvation counter lets a background port preempt port 0
//     for one grant after STARVE_LIMIT consecutive denied cycles.
//   - Read data returns to the originating port after a fixed
//     ROM_LATENCY+1 cycles, steered by a (valid, port) tag pipeline.
//
// Parameters
//   ROM_LATENCY   ROM read latency, address-sampling edge to valid douta (1..3)
//   STARVE_LIMIT  denied cycles before a port 1-3 preempts port 0 (2..15)
//
// Ports
//   vga_clock   in   1   sole clock
//   reset       in   1   asynchronous, active-high reset
//   req         in   4   per-port request, held with a stable address until granted
//   addr0..3    in  11   per-port ROM address {bot_type[2:0], row[3:0], col[3:0]}
//   gnt         out  4   one-hot combinational grant for the current cycle
//   rom_addr    out 11   winner's address, combinational, to ROM addra
//   rom_data    in   2   ROM douta
//   rdata       out  2   registered read data, holds while rvalid is 0
//   rvalid      out  4   registered one-hot owner of rdata this cycle
//   port0_miss  out  1   registered pulse: port 0 requested and was denied last cycle
//   miss_count  out  8   saturating count of port0_miss pulses
// -----------------------------------------------------------------------------
module icon_rom_arbiter #(
    parameter int ROM_LATENCY  = 1,
    parameter int STARVE_LIMIT = 8
) (
    input  logic        vga_clock,
    input  logic        reset,
    input  logic [3:0]  req,
    input  logic [10:0] addr0,
    input  logic [10:0] addr1,
    input  logic [10:0] addr2,
    input  logic [10:0] addr3,
    output logic [3:0]  gnt,
    output logic [10:0] rom_addr,
    input  logic [1:0]  rom_data,
    output logic [1:0]  rdata,
    output logic [3:0]  rvalid,
    output logic        port0_miss,
    output logic [7:0]  miss_count
);

    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    // One entry of the read-return pipeline: which port a ROM access belongs to.
    typedef struct packed {
        logic       valid;
        logic [1:0] port;
    } tag_t;

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    logic [1:0]       rr_ptr;        // last background port granted (1..3)
    logic [3:1][3:0]  starve_cnt;    // consecutive denied cycles, ports 1-3
    tag_t             tag_pipe [ROM_LATENCY];

    // -------------------------------------------------------------------------
    // Combinational arbitration
    // -------------------------------------------------------------------------
    logic [3:0] starved;
    logic [1:0] win_idx;
    logic       miss_now;
    tag_t       tag_out;

    // Round-robin successor over the background ports: 1 -> 2 -> 3 -> 1.
    function automatic logic [1:0] rr_next(input logic [1:0] p);
        case (p)
            2'd1:    return 2'd2;
            2'd2:    return 2'd3;
            default: return 2'd1;
        endcase
    endfunction

    // First candidate among ports 1-3, searching from ptr+1 with wrap.
    // Bit 0 of cand is never examined; callers keep it zero.
    function automatic logic [3:0] rr_pick(input logic [3:0] cand, input logic [1:0] ptr);
        logic [1:0] p;
        logic [3:0] pick;
        pick = '0;
        p    = ptr;
        for (int k = 0; k < 3; k++) begin
            p = rr_next(p);
            if (pick == '0 && cand[p]) begin
                pick[p] = 1'b1;
            end
        end
        return pick;
    endfunction

    always_comb begin
        // NOTE: every signal driven here gets a default before any branch, so
        // no path leaves a value unassigned and no latch is inferred.
        starved = '0;
        for (int i = 1; i < 4; i++) begin
            starved[i] = req[i] && (starve_cnt[i] == LIMIT);
        end

        gnt = '0;
        if (reset) begin
            gnt = '0;
        end else if (starved != '0) begin
            gnt = rr_pick(starved, rr_ptr);
        end else if (req[0]) begin
            gnt = 4'b0001;
        end else begin
            gnt = rr_pick(req & 4'b1110, rr_ptr);
        end
    end

    // Grant encoding and address mux; gnt is one-hot or zero.
    always_comb begin
        win_idx  = 2'd0;
        rom_addr = '0;
        if (gnt[0]) begin
            win_idx  = 2'd0;
            rom_addr = addr0;
        end
        if (gnt[1]) begin
            win_idx  = 2'd1;
            rom_addr = addr1;
        end
        if (gnt[2]) begin
            win_idx  = 2'd2;
            rom_addr = addr2;
        end
        if (gnt[3]) begin
            win_idx  = 2'd3;
            rom_addr = addr3;
        end
    end

    assign miss_now = req[0] && !gnt[0];
    assign tag_out  = tag_pipe[ROM_LATENCY-1];

    // -------------------------------------------------------------------------
    // Sequential state
    // -------------------------------------------------------------------------
    always_ff @(posedge vga_clock or posedge reset) begin
        if (reset) begin
            rr_ptr     <= 2'd3;
            starve_cnt <= '0;
            // NOTE: the tag pipeline is reset, unlike a plain data delay line,
            // because a stale valid tag would emit rvalid for a read that
            // reset has discarded.
            for (int k = 0; k < ROM_LATENCY; k++) begin
                tag_pipe[k] <= '0;
            end
            rdata      <= '0;
            rvalid     <= '0;
            port0_miss <= 1'b0;
            miss_count <= '0;
        end else begin
            // NOTE: state updates use non-blocking assignments so every
            // register samples the pre-edge values of the others.
            if (gnt[3:1] != '0) begin
                rr_ptr <= win_idx;
            end

            // Clear on grant or idle; otherwise count up and stick at the limit.
            for (int i = 1; i < 4; i++) begin
                if (!req[i] || gnt[i]) begin
                    starve_cnt[i] <= '0;
                end else if (starve_cnt[i] != LIMIT) begin
                    starve_cnt[i] <= starve_cnt[i] + 4'd1;
                end
            end

            // The tag reaching the last stage lines up with the ROM data
            // for the same access, which is captured into rdata.
            tag_pipe[0] <= '{valid: (gnt != '0), port: win_idx};
            for (int k = 1; k < ROM_LATENCY; k++) begin
                tag_pipe[k] <= tag_pipe[k-1];
            end

            rvalid <= tag_out.valid ? (4'b0001 << tag_out.port) : 4'b0000;
            if (tag_out.valid) begin
                rdata <= rom_data;
            end

            // The count steps on the same edge that raises the pulse, so it
            // already includes the pulse visible in the same cycle.
            port0_miss <= miss_now;
            if (miss_now && miss_count != 8'hFF) begin
                miss_count <= miss_count + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_icon_rom_arbiter.sv
// -----------------------------------------------------------------------------
// tb_icon_rom_arbiter
//
// Directed bench for icon_rom_arbiter. Two instances share clock, reset and
// requester inputs:
//   dut_a  ROM_LATENCY=1, STARVE_LIMIT=8
//   dut_b  ROM_LATENCY=3, STARVE_LIMIT=2
// Each instance drives its own ROM model with matching latency. Inputs change
// 1 time unit after the rising edge; outputs are sampled on the falling edge.
// -----------------------------------------------------------------------------
module tb_icon_rom_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  req;
    logic [10:0] addr0, addr1, addr2, addr3;

    logic [3:0]  gnt_a, rvalid_a, gnt_b, rvalid_b;
    logic [10:0] rom_addr_a, rom_addr_b;
    logic [1:0]  rom_data_a, rom_data_b, rdata_a, rdata_b;
    logic        port0_miss_a, port0_miss_b;
    logic [7:0]  miss_count_a, miss_count_b;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    icon_rom_arbiter #(.ROM_LATENCY(1), .STARVE_LIMIT(8)) dut_a (
        .vga_clock (clk),
        .reset     (reset),
        .req       (req),
        .addr0     (addr0),
        .addr1     (addr1),
        .addr2     (addr2),
        .addr3     (addr3),
        .gnt       (gnt_a),
        .rom_addr  (rom_addr_a),
        .rom_data  (rom_data_a),
        .rdata     (rdata_a),
        .rvalid    (rvalid_a),
        .port0_miss(port0_miss_a),
        .miss_count(miss_count_a)
    );

    icon_rom_arbiter #(.ROM_LATENCY(3), .STARVE_LIMIT(2)) dut_b (
        .vga_clock (clk),
        .reset     (reset),
        .req       (req),
        .addr0     (addr0),
        .addr1     (addr1),
        .addr2     (addr2),
        .addr3     (addr3),
        .gnt       (gnt_b),
        .rom_addr  (rom_addr_b),
        .rom_data  (rom_data_b),
        .rdata     (rdata_b),
        .rvalid    (rvalid_b),
        .port0_miss(port0_miss_b),
        .miss_count(miss_count_b)
    );

    // ROM contents: a fixed function of the address.
    function automatic logic [1:0] rom_val(input logic [10:0] a);
        return a[1:0] ^ a[5:4];
    endfunction

    // ROM models: address sampled at the edge ending the grant cycle,
    // data valid ROM_LATENCY cycles later.
    logic [1:0] rom_a_q;
    logic [1:0] rom_b_q [3];
    always @(posedge clk) begin
        rom_a_q    <= rom_val(rom_addr_a);
        rom_b_q[0] <= rom_val(rom_addr_b);
        rom_b_q[1] <= rom_b_q[0];
        rom_b_q[2] <= rom_b_q[1];
    end
    assign rom_data_a = rom_a_q;
    assign rom_data_b = rom_b_q[2];

    function automatic logic [10:0] addr_of(input logic [3:0] onehot);
        case (onehot)
            4'b0001: return addr0;
            4'b0010: return addr1;
            4'b0100: return addr2;
            4'b1000: return addr3;
            default: return 11'h000;
        endcase
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // Pulse reset for two cycles, then leave one idle cycle.
    task automatic do_reset();
        next_cycle();
        reset = 1'b1;
        req   = 4'b0000;
        next_cycle();
        next_cycle();
        reset = 1'b0;
    endtask

    logic [3:0] exp_rr [8];
    logic [3:0] exp_ds [8];

    initial begin
        // ---------------- reset state, with all requests raised ------------
        reset = 1'b1;
        req   = 4'b1111;
        addr0 = 11'h001; addr1 = 11'h002; addr2 = 11'h003; addr3 = 11'h004;
        @(negedge clk);
        check("rst_gnt",      gnt_a,        4'b0000);
        check("rst_rom_addr", rom_addr_a,   11'h000);
        check("rst_rvalid",   rvalid_a,     4'b0000);
        check("rst_rdata",    rdata_a,      2'b00);
        check("rst_miss",     port0_miss_a, 1'b0);
        check("rst_count",    miss_count_a, 8'd0);
        next_cycle();
        reset = 1'b0;
        req   = 4'b0000;

        // ---------------- port 0 only, latency 1 ---------------------------
        next_cycle();
        req   = 4'b0001;
        addr0 = 11'h1A5;
        @(negedge clk);
        check("p0_gnt",      gnt_a,      4'b0001);
        check("p0_rom_addr", rom_addr_a, 11'h1A5);
        next_cycle();
        req = 4'b0000;
        @(negedge clk);
        check("p0_rvalid_c1", rvalid_a,     4'b0000);
        check("p0_miss_c1",   port0_miss_a, 1'b0);
        next_cycle();
        @(negedge clk);
        check("p0_rvalid_c2", rvalid_a,     4'b0001);
        check("p0_rdata_c2",  rdata_a,      2'd3);
        check("p0_miss_c2",   port0_miss_a, 1'b0);

        // ---------------- round-robin among ports 1-3 ----------------------
        exp_rr = '{4'b0010, 4'b0100, 4'b1000, 4'b0010, 4'b0100, 4'b1000, 4'b0000, 4'b0000};
        addr1 = 11'h101; addr2 = 11'h202; addr3 = 11'h303;
        for (int c = 0; c < 8; c++) begin
            next_cycle();
            req = (c < 6) ? 4'b1110 : 4'b0000;
            @(negedge clk);
            check($sformatf("rr_gnt_c%0d", c), gnt_a, exp_rr[c]);
            if (c >= 2) begin
                check($sformatf("rr_rvalid_c%0d", c), rvalid_a, exp_rr[c-2]);
                check($sformatf("rr_rdata_c%0d", c), rdata_a, rom_val(addr_of(exp_rr[c-2])));
            end
        end

        // ---------------- starvation override, limit 8 ---------------------
        do_reset();
        addr0 = 11'h0AA; addr1 = 11'h156;
        for (int c = 0; c <= 10; c++) begin
            next_cycle();
            req = 4'b0011;
            @(negedge clk);
            if (c <= 9) begin
                check($sformatf("sv_gnt_c%0d", c), gnt_a,
                      (c == 8) ? 4'b0010 : 4'b0001);
            end
            check($sformatf("sv_miss_c%0d", c), port0_miss_a, (c == 9) ? 1'b1 : 1'b0);
            if (c >= 8) begin
                check($sformatf("sv_count_c%0d", c), miss_count_a, (c >= 9) ? 8'd1 : 8'd0);
            end
            if (c == 9) check("sv_rvalid_c9", rvalid_a, 4'b0001);
            if (c == 10) begin
                check("sv_rvalid_c10", rvalid_a, 4'b0010);
                check("sv_rdata_c10",  rdata_a,  2'd3);
            end
        end

        // ---------------- double starvation, limit 2, latency 3 ------------
        do_reset();
        addr0 = 11'h000; addr1 = 11'h001; addr2 = 11'h002; addr3 = 11'h003;
        exp_ds = '{4'b0001, 4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0010, 4'b0100, 4'b1000};
        for (int c = 0; c < 8; c++) begin
            next_cycle();
            req = 4'b1111;
            @(negedge clk);
            check($sformatf("ds_gnt_c%0d", c), gnt_b, exp_ds[c]);
            if (c >= 4) begin
                check($sformatf("ds_rvalid_c%0d", c), rvalid_b, exp_ds[c-4]);
                check($sformatf("ds_rdata_c%0d", c), rdata_b, rom_val(addr_of(exp_ds[c-4])));
            end
        end
        check("ds_count_c7", miss_count_b, 8'd5);

        // drain: rdata_b ends holding the port 3 read (value 3)
        for (int c = 0; c < 6; c++) begin
            next_cycle();
            req = 4'b0000;
        end

        // ---------------- reset mid-flight, latency 3 ----------------------
        next_cycle();
        req   = 4'b0100;
        addr2 = 11'h2C6;
        @(negedge clk);
        check("rm_gnt_c0",      gnt_b,      4'b0100);
        check("rm_rom_addr_c0", rom_addr_b, 11'h2C6);
        check("rm_rdata_pre",   rdata_b,    2'd3);
        next_cycle();
        req = 4'b0000;
        next_cycle();
        reset = 1'b1;
        req   = 4'b1111;
        @(negedge clk);
        check("rm_gnt_rst",      gnt_b,        4'b0000);
        check("rm_rom_addr_rst", rom_addr_b,   11'h000);
        check("rm_rvalid_rst",   rvalid_b,     4'b0000);
        check("rm_rdata_rst",    rdata_b,      2'b00);
        check("rm_count_rst",    miss_count_b, 8'd0);
        next_cycle();
        next_cycle();
        reset = 1'b0;
        req   = 4'b0000;
        for (int c = 4; c < 10; c++) begin
            @(negedge clk);
            check($sformatf("rm_rvalid_c%0d", c), rvalid_b, 4'b0000);
            next_cycle();
        end
        req = 4'b1110;
        @(negedge clk);
        check("rm_rr_start", gnt_b, 4'b0010);
        check("rm_count_post", miss_count_b, 8'd0);

        // ---------------- miss_count saturation ----------------------------
        do_reset();
        for (int c = 0; c < 400; c++) begin
            next_cycle();
            req = 4'b1111;
            if (c == 100 || c == 257 || c == 258 || c == 399) begin
                @(negedge clk);
                check($sformatf("sat_count_c%0d", c), miss_count_b,
                      (c == 100) ? 8'd98 : 8'd255);
            end
        end
        @(negedge clk);
        check("sat_miss_pulse", port0_miss_b, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
